// File: rtl/prmcu_uart_tx_fifo.sv
// Buffered UART transmitter: FIFO of FIFO_DEPTH words feeding a 5..9 bit serialiser
// with optional parity, 1/2 stop bits, per-bit clock divider and line-break generation.
module prmcu_uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_en,
    input  logic [3:0]                    n_data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic [1:0]                    n_stop_bits,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          send_break,
    input  logic [8:0]                    in_dat_i,
    input  logic                          in_vld_i,
    output logic                          in_rdy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          busy_o,
    output logic                          tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MARK} state_t;

    function automatic logic [3:0] clamp_bits(input logic [3:0] n);
        if (n < 4'd5) return 4'd5;
        else if (n > 4'd9) return 4'd9;
        else return n;
    endfunction

    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

    function automatic logic parity_bit(input logic [8:0] d, input logic [3:0] n, input logic odd);
        logic [8:0] mask;
        mask = 9'((10'd1 << n) - 10'd1);
        return (^(d & mask)) ^ odd;
    endfunction

    state_t             state_q, state_d;
    logic               tx_q, tx_d, busy_q, busy_d;
    logic [8:0]         shift_q, shift_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]   timer_q, timer_d, div_q, div_d;
    logic               par_en_q, par_en_d, par_bit_q, par_bit_d, stop2_q, stop2_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [8:0]         mem_q [FIFO_DEPTH];

    logic               push, pop, empty, full, bit_end, start_idle;
    logic [3:0]         cfg_bits, cfg_total;
    logic [DIV_W-1:0]   cfg_div;
    logic               cfg_par_en, cfg_odd, cfg_stop2;
    logic [8:0]         head;

    assign empty     = (level_q == '0);
    assign full      = (level_q == LW'(FIFO_DEPTH));
    assign in_rdy_o  = !rst && !full;
    assign push      = in_vld_i && in_rdy_o;
    assign head      = mem_q[rd_ptr_q];

    assign cfg_bits   = clamp_bits(n_data_bits);
    assign cfg_div    = clamp_div(baud_div);
    assign cfg_par_en = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    assign cfg_odd    = (parity_mode == 2'b10);
    assign cfg_stop2  = (n_stop_bits >= 2'd2);
    assign cfg_total  = 4'd1 + cfg_bits + {3'd0, cfg_par_en} + (cfg_stop2 ? 4'd2 : 4'd1);

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        div_d      = div_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        pop        = 1'b0;
        start_idle = 1'b0;
        bit_end    = (timer_q == '0);
        timer_d    = bit_end ? div_q - DIV_W'(1) : timer_q - DIV_W'(1);

        unique case (state_q)
            S_IDLE: start_idle = 1'b1;
            S_START: if (bit_end) begin
                state_d = S_DATA;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
            end
            S_DATA: if (bit_end) begin
                if (bit_cnt_q != 4'd0) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end else if (par_en_q) begin
                    state_d = S_PARITY;
                    tx_d    = par_bit_q;
                end else begin
                    state_d   = S_STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = {3'd0, stop2_q};
                end
            end
            S_PARITY: if (bit_end) begin
                state_d   = S_STOP;
                tx_d      = 1'b1;
                bit_cnt_d = {3'd0, stop2_q};
            end
            S_STOP: if (bit_end) begin
                if (bit_cnt_q != 4'd0) bit_cnt_d = bit_cnt_q - 4'd1;
                else start_idle = 1'b1;
            end
            // Break runs whole bit times; it only ends on a bit boundary once released.
            S_BREAK: if (bit_end) begin
                if (bit_cnt_q != 4'd0) bit_cnt_d = bit_cnt_q - 4'd1;
                else if (!send_break) begin
                    state_d = S_MARK;
                    tx_d    = 1'b1;
                end
            end
            S_MARK: if (bit_end) start_idle = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Frame-end states share the idle decision so consecutive frames run without a gap.
        if (start_idle) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            if (send_break) begin
                state_d   = S_BREAK;
                tx_d      = 1'b0;
                div_d     = cfg_div;
                timer_d   = cfg_div - DIV_W'(1);
                bit_cnt_d = cfg_total - 4'd1;
            end else if (tx_en && !empty) begin
                pop       = 1'b1;
                state_d   = S_START;
                tx_d      = 1'b0;
                shift_d   = head;
                div_d     = cfg_div;
                timer_d   = cfg_div - DIV_W'(1);
                bit_cnt_d = cfg_bits - 4'd1;
                par_en_d  = cfg_par_en;
                par_bit_d = parity_bit(head, cfg_bits, cfg_odd);
                stop2_d   = cfg_stop2;
            end
        end

        busy_d   = (state_d != S_IDLE);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q;
        if (push && !pop) level_d = level_q + LW'(1);
        else if (pop && !push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
        shift_q   <= shift_d;
        bit_cnt_q <= bit_cnt_d;
        timer_q   <= timer_d;
        div_q     <= div_d;
        par_en_q  <= par_en_d;
        par_bit_q <= par_bit_d;
        stop2_q   <= stop2_d;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_dat_i;
    end

    assign fifo_level_o = level_q;
    assign busy_o       = busy_q;
    assign tx_o         = tx_q;
endmodule

// File: tb/tb_prmcu_uart_tx_fifo.sv
// Scoreboard bench for prmcu_uart_tx_fifo: stimulus queues expected line waveforms,
// a monitor checks every cycle of each frame as the DUT transmits it.
module tb_prmcu_uart_tx_fifo;
    localparam int DEPTH = 8;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst, tx_en, send_break, in_vld_i, in_rdy_o, busy_o, tx_o;
    logic [3:0]    n_data_bits;
    logic [1:0]    parity_mode, n_stop_bits;
    logic [DW-1:0] baud_div;
    logic [8:0]    in_dat_i;
    logic [3:0]    fifo_level_o;

    prmcu_uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .n_data_bits(n_data_bits),
        .parity_mode(parity_mode), .n_stop_bits(n_stop_bits), .baud_div(baud_div),
        .send_break(send_break), .in_dat_i(in_dat_i), .in_vld_i(in_vld_i),
        .in_rdy_o(in_rdy_o), .fifo_level_o(fifo_level_o), .busy_o(busy_o), .tx_o(tx_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
        bit          gap0;
    } frame_t;

    frame_t exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_end = -100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] frame8(input logic [7:0] d);
        return 16'h0200 | {7'd0, d, 1'b0};
    endfunction

    // Monitor: one sample per cycle, just after the active edge.
    initial begin : monitor
        frame_t f;
        int     bad;
        bit     aborted;
        forever begin
            @(posedge clk); #1;
            if (!rst && tx_o === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_start", tx_o, 1);
                end else begin
                    f = exp_q.pop_front();
                    if (f.gap0) check("no_gap_start_cycle", cyc, last_end + 1);
                    aborted = 1'b0;
                    for (int b = 0; b < f.nbits && !aborted; b++) begin
                        bad = 0;
                        for (int c = 0; c < f.div && !aborted; c++) begin
                            if (b != 0 || c != 0) begin @(posedge clk); #1; end
                            if (rst) aborted = 1'b1;
                            else if (tx_o !== f.bits[b] || busy_o !== 1'b1) bad++;
                        end
                        if (!aborted) check($sformatf("bit%0d_bad_cycles", b), bad, 0);
                    end
                    last_end = cyc;
                    if (!aborted && exp_q.size() == 0) begin
                        @(posedge clk); #1;
                        if (!rst) check("busy_after_frame", busy_o, 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic cfg(input int nb, input int pm, input int ns, input int dv);
        n_data_bits = 4'(nb);
        parity_mode = 2'(pm);
        n_stop_bits = 2'(ns);
        baud_div    = DW'(dv);
    endtask

    task automatic expect_frame(input logic [15:0] bits, input int nbits, input int div, input bit gap0);
        frame_t f;
        f.bits = bits; f.nbits = nbits; f.div = div; f.gap0 = gap0;
        exp_q.push_back(f);
    endtask

    task automatic push_word(input logic [8:0] d, input logic [15:0] bits, input int nbits,
                             input int div, input bit gap0, output bit acc);
        in_dat_i = d;
        in_vld_i = 1'b1;
        acc = in_rdy_o;
        if (acc) expect_frame(bits, nbits, div, gap0);
        @(negedge clk);
        in_vld_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy_o) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_completed_in_budget"}, (t < 3000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : stim
        bit acc;
        int n_acc;
        logic [7:0] words [10];
        words = '{8'h00, 8'hFF, 8'h0F, 8'hF0, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h11, 8'h22};
        rst = 1'b1; tx_en = 1'b0; send_break = 1'b0; in_vld_i = 1'b0; in_dat_i = '0;
        cfg(8, 0, 0, 4);
        repeat (3) @(negedge clk);
        check("rdy_during_reset", in_rdy_o, 0);
        check("tx_reset", tx_o, 1);
        check("busy_reset", busy_o, 0);
        check("level_reset", fifo_level_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_reset", in_rdy_o, 1);

        // 8N1, div 4, 0x055
        tx_en = 1'b1;
        push_word(9'h055, 16'h02AA, 10, 4, 1'b0, acc);
        check("t1_accept", acc, 1);
        check("t1_level_after_accept", fifo_level_o, 1);
        check("t1_tx_before_pop", tx_o, 1);
        @(negedge clk);
        check("t1_tx_start", tx_o, 0);
        check("t1_busy_start", busy_o, 1);
        check("t1_level_after_pop", fifo_level_o, 0);
        wait_idle("t1");

        // 7E1, div 3, 0x107: bit 8 ignored
        cfg(7, 1, 0, 3);
        push_word(9'h107, 16'h030E, 10, 3, 1'b0, acc);
        wait_idle("t2");

        // 9O2, div 1 clamps to 2, 0x1FF
        cfg(9, 2, 2, 1);
        push_word(9'h1FF, 16'h1BFE, 13, 2, 1'b0, acc);
        wait_idle("t3");

        // n_data_bits 3 -> 5, parity 11 -> none, n_stop_bits 3 -> 2
        cfg(3, 3, 3, 2);
        push_word(9'h0F3, 16'h00E6, 8, 2, 1'b0, acc);
        wait_idle("t3b");

        // Fill the FIFO with tx disabled, then drain back-to-back
        tx_en = 1'b0;
        cfg(8, 0, 0, 2);
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            push_word({1'b0, words[i]}, frame8(words[i]), 10, 2, (i > 0), acc);
            if (acc) n_acc++;
        end
        check("t4_accepted", n_acc, 8);
        check("t4_rdy_full", in_rdy_o, 0);
        check("t4_level_full", fifo_level_o, 8);
        tx_en = 1'b1;
        @(negedge clk);
        check("t4_level_after_first_pop", fifo_level_o, 7);
        wait_idle("t4");
        check("t4_level_drained", fifo_level_o, 0);

        // Break pulse has priority over queued data, then the queued word follows the mark
        tx_en = 1'b0;
        cfg(8, 0, 0, 4);
        expect_frame(16'h0400, 11, 4, 1'b0);
        push_word(9'h03C, frame8(8'h3C), 10, 4, 1'b1, acc);
        send_break = 1'b1;
        tx_en = 1'b1;
        @(negedge clk);
        send_break = 1'b0;
        check("t5_break_tx", tx_o, 0);
        check("t5_break_level", fifo_level_o, 1);
        wait_idle("t5");

        // Reset in the middle of DATA with three words still queued
        tx_en = 1'b0;
        cfg(8, 0, 0, 4);
        for (int i = 0; i < 4; i++) push_word(9'h0A5, frame8(8'hA5), 10, 4, (i > 0), acc);
        tx_en = 1'b1;
        repeat (12) @(negedge clk);
        check("t6_level_before_reset", fifo_level_o, 3);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        check("t6_tx_after_reset", tx_o, 1);
        check("t6_level_after_reset", fifo_level_o, 0);
        check("t6_busy_after_reset", busy_o, 0);
        check("t6_rdy_in_reset", in_rdy_o, 0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("t6_level_idle", fifo_level_o, 0);
        check("t6_busy_idle", busy_o, 0);
        check("t6_rdy_idle", in_rdy_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
